// File: rtl/mvm_frame_deserializer.sv
// Receive-side framing for the UART matrix-vector multiply system.
// Hunts for SYNC_WORD, collects R*C matrix words then C vector words, checks
// an XOR checksum, and presents a good frame on m_k/m_x under valid/ready.
// A bad frame is dropped, pulses err_pulse and bumps a saturating err_count.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_data/s_valid/s_ready   byte stream from the UART receiver
//   m_k, m_x            flat operand buses (k[r][c] at (r*C+c)*W_K, x[c] at c*W_X)
//   m_valid/m_ready     frame handshake toward the MVM core
//   err_pulse           one-cycle pulse after a checksum mismatch
//   err_count           dropped-frame count, saturates at 255
module mvm_frame_deserializer #(
  parameter int unsigned              BITS_PER_WORD = 8,
  parameter int unsigned              R             = 4,
  parameter int unsigned              C             = 4,
  parameter int unsigned              W_K           = 4,
  parameter int unsigned              W_X           = 4,
  parameter logic [BITS_PER_WORD-1:0] SYNC_WORD     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_PER_WORD-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [R*C*W_K-1:0]       m_k,
  output logic [C*W_X-1:0]         m_x,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     err_pulse,
  output logic [7:0]               err_count
);

  localparam int unsigned NK    = R * C;
  localparam int unsigned N     = NK + C;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BITS_PER_WORD-1:0] acc_q, acc_d;
  logic [R*C*W_K-1:0]       m_k_q, m_k_d;
  logic [C*W_X-1:0]         m_x_q, m_x_d;
  logic                     err_pulse_q, err_pulse_d;
  logic [7:0]               err_count_q, err_count_d;
  logic                     accept;

  // Handshake flags are pure decodes of the registered state.
  assign s_ready   = (state_q != HOLD);
  assign m_valid   = (state_q == HOLD);
  assign accept    = s_valid & s_ready;
  assign m_k       = m_k_q;
  assign m_x       = m_x_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  // Next-state, payload capture and checksum accumulation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    m_k_d       = m_k_q;
    m_x_d       = m_x_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept && (s_data == SYNC_WORD)) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      PAYLOAD: begin
        if (accept) begin
          acc_d = acc_q ^ s_data;
          cnt_d = cnt_q + CNT_W'(1);
          // Operands are written in place; sync-valued bytes are plain data here.
          for (int unsigned i = 0; i < NK; i++) begin
            if (cnt_q == CNT_W'(i)) m_k_d[i*W_K +: W_K] = s_data[W_K-1:0];
          end
          for (int unsigned i = 0; i < C; i++) begin
            if (cnt_q == CNT_W'(NK + i)) m_x_d[i*W_X +: W_X] = s_data[W_X-1:0];
          end
          if (cnt_q == CNT_W'(N - 1)) state_d = CHECK;
        end
      end

      CHECK: begin
        if (accept) begin
          if (s_data == acc_q) begin
            state_d = HOLD;
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
      end

      HOLD: begin
        if (m_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      m_k_q       <= '0;
      m_x_q       <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      m_k_q       <= m_k_d;
      m_x_q       <= m_x_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mvm_frame_deserializer.sv
// Directed, table-driven bench for mvm_frame_deserializer (default parameters).
module tb_mvm_frame_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_k;
  logic [15:0] m_x;
  logic        m_valid;
  logic        m_ready;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  mvm_frame_deserializer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_k(m_k), .m_x(m_x), .m_valid(m_valid), .m_ready(m_ready),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pat;       // payload pattern id
    int          n_garbage; // junk words before sync
    logic [7:0]  chk;       // checksum word sent
    int          gap_max;   // random idle cycles before each word
    int          hold;      // cycles m_ready stays low after m_valid
    logic        exp_valid;
    logic [63:0] exp_k;
    logic [15:0] exp_x;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pay(input int pat, input int i);
    logic [7:0] xw [4];
    xw[0] = 8'h5A; xw[1] = 8'hA5; xw[2] = 8'h3C; xw[3] = 8'hC3;
    if (pat == 0) return 8'(i + 1);
    if (i < 16)   return 8'hF0 | 8'(15 - i);
    return xw[i - 16];
  endfunction

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [7:0] w, input int gap_max);
    int budget;
    if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    budget  = 50;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_word_timeout: s_ready stuck at 0 expected 1 at %0t", $time);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int pat, input int n_garbage, input logic [7:0] chk,
                            input int gap_max, input bit with_sync);
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h5A;
    for (int g = 0; g < n_garbage; g++) send_word(junk[g % 3], gap_max);
    if (with_sync) send_word(8'hA5, gap_max);
    for (int i = 0; i < 20; i++) send_word(pay(pat, i), gap_max);
    send_word(chk, gap_max);
  endtask

  // Checks taken at the negedge right after the checksum word was accepted.
  task automatic check_result(input vec_t v);
    check("m_valid_after_chk", m_valid, v.exp_valid);
    check("err_pulse_after_chk", err_pulse, !v.exp_valid);
    check("err_count_after_chk", err_count, v.exp_err);
    if (v.exp_valid) begin
      check("m_k", m_k, v.exp_k);
      check("m_x", m_x, v.exp_x);
      check("s_ready_in_hold", s_ready, 1'b0);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check("hold_m_valid", m_valid, 1'b1);
        check("hold_s_ready", s_ready, 1'b0);
        check("hold_m_k_stable", m_k, v.exp_k);
        check("hold_m_x_stable", m_x, v.exp_x);
      end
      m_ready = 1'b1;
      @(negedge clk);
      check("m_valid_after_hs", m_valid, 1'b0);
      check("s_ready_after_hs", s_ready, 1'b1);
    end else begin
      @(negedge clk);
      check("err_pulse_one_cycle", err_pulse, 1'b0);
      check("m_valid_bad_frame", m_valid, 1'b0);
    end
  endtask

  initial begin
    vec_t bp;
    vecs[0] = '{0, 0, 8'h14, 0, 0,  1'b1, 64'h0FEDCBA987654321, 16'h4321, 8'd0};
    vecs[1] = '{0, 0, 8'h15, 0, 0,  1'b0, 64'h0,                16'h0,    8'd1};
    vecs[2] = '{0, 0, 8'h14, 0, 0,  1'b1, 64'h0FEDCBA987654321, 16'h4321, 8'd1};
    vecs[3] = '{1, 3, 8'h00, 0, 0,  1'b1, 64'h0123456789ABCDEF, 16'h3C5A, 8'd1};
    vecs[4] = '{0, 3, 8'h14, 0, 0,  1'b1, 64'h0FEDCBA987654321, 16'h4321, 8'd1};
    vecs[5] = '{0, 0, 8'h14, 3, 10, 1'b1, 64'h0FEDCBA987654321, 16'h4321, 8'd1};

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_k", m_k, 64'h0);
    check("rst_m_x", m_x, 16'h0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_count", err_count, 8'd0);

    for (int t = 0; t < 6; t++) begin
      m_ready = (vecs[t].hold == 0);
      send_frame(vecs[t].pat, vecs[t].n_garbage, vecs[t].chk, vecs[t].gap_max, 1'b1);
      check_result(vecs[t]);
      repeat (2) @(negedge clk);
    end

    // Next sync word held on s_valid during HOLD is taken right after the handshake.
    m_ready = 1'b0;
    send_frame(0, 0, 8'h14, 0, 1'b1);
    check("bp_m_valid", m_valid, 1'b1);
    s_data = 8'hA5; s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_s_ready_hold", s_ready, 1'b0);
      check("bp_m_valid_hold", m_valid, 1'b1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_m_valid_drop", m_valid, 1'b0);
    check("bp_s_ready_back", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) send_word(pay(1, i), 0);
    send_word(8'h00, 0);
    bp = '{1, 0, 8'h00, 0, 0, 1'b1, 64'h0123456789ABCDEF, 16'h3C5A, 8'd1};
    check_result(bp);

    // Reset after seven payload words abandons the frame without counting it.
    send_word(8'hA5, 0);
    for (int i = 0; i < 7; i++) send_word(pay(0, i), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_k", m_k, 64'h0);
    check("midrst_err_count", err_count, 8'd0);
    check("midrst_s_ready", s_ready, 1'b1);
    check("midrst_m_valid", m_valid, 1'b0);
    send_frame(0, 0, 8'h14, 0, 1'b1);
    check_result('{0, 0, 8'h14, 0, 0, 1'b1, 64'h0FEDCBA987654321, 16'h4321, 8'd0});

    // Saturation: 300 bad frames.
    for (int b = 1; b <= 300; b++) begin
      send_frame(0, 0, 8'h15, 0, 1'b1);
      check("sat_err_pulse", err_pulse, 1'b1);
      check("sat_err_count", err_count, (b > 255) ? 64'd255 : 64'(b));
      @(negedge clk);
      check("sat_err_pulse_low", err_pulse, 1'b0);
    end
    check("sat_final", err_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
